serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor: computes A − B one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the inverse-direction counterpart to the 1-bit full adder.
- Sits in the ALU datapath wherever area matters more than latency.
- Start/busy/done handshake; results and flags are held until the next operation.

---
 rtl/serial_subtractor.sv | 165 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor. Computes a - b one bit per clock, LSB first,
// with a single full-subtractor cell and a registered borrow. An operation is
// accepted from IDLE, takes WIDTH RUN cycles and then signals done for one
// cycle. Result and flags are held until the next operation completes.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request; only sampled in IDLE
//   a, b      in   minuend / subtrahend, captured on the accepting edge
//   busy      out  high while bits are being processed (RUN)
//   done      out  one-cycle pulse, results valid
//   diff      out  a - b modulo 2^WIDTH
//   borrow    out  unsigned borrow-out (a < b)
//   overflow  out  signed two's-complement overflow
//   zero      out  diff == 0
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] op_a_q,     op_a_d;
  logic [WIDTH-1:0] op_b_q,     op_b_d;
  logic [WIDTH-1:0] res_q,      res_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             br_q,       br_d;
  logic             a_msb_q,    a_msb_d;
  logic             b_msb_q,    b_msb_d;
  logic [WIDTH-1:0] diff_q,     diff_d;
  logic             borrow_q,   borrow_d;
  logic             overflow_q, overflow_d;
  logic             zero_q,     zero_d;

  // Full-subtractor cell operating on the current LSBs and the borrow flop.
  logic ai, bi, d_bit, br_next;
  assign ai      = op_a_q[0];
  assign bi      = op_b_q[0];
  assign d_bit   = ai ^ bi ^ br_q;
  assign br_next = (~ai & bi) | (~(ai ^ bi) & br_q);

  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the
    // case statement leaves it unassigned; otherwise a latch is inferred.
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    br_d       = br_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          // Original sign bits are kept because the operand registers shift.
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        op_a_d = op_a_q >> 1;
        op_b_d = op_b_q >> 1;
        // Result fills from the MSB end so bit 0 lands in place after WIDTH shifts.
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d      = '0;
          state_d    = S_DONE;
          diff_d     = res_d;
          borrow_d   = br_next;
          // d_bit is the MSB of the finished difference on this edge.
          overflow_d = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          zero_d     = (res_d == '0);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      br_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      br_q       <= br_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WIDTH = 8). A behavioural model
// tracks each accepted operation as "accepted at edge k" and derives the
// result with plain integer arithmetic; a compare process checks every DUT
// output against it on each falling edge. Directed cases pin the model with
// literal expectations; random operations and a held-start run follow.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, borrow, overflow, zero;
  logic [W-1:0] diff;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. ph = -1 when idle, otherwise the number of edges since
  // the accepting edge (busy for 0..W-1, done at W).
  // ---------------------------------------------------------------------------
  int           ph       = -1;
  logic [W-1:0] m_a      = '0;
  logic [W-1:0] m_b      = '0;
  logic [W-1:0] m_diff   = '0;
  logic         m_borrow = 1'b0;
  logic         m_ovf    = 1'b0;
  logic         m_zero   = 1'b0;
  int           sa, sb, sd;

  function automatic int to_signed(input logic [W-1:0] v);
    return (int'(v) >= 2 ** (W - 1)) ? int'(v) - 2 ** W : int'(v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph       = -1;
      m_diff   = '0;
      m_borrow = 1'b0;
      m_ovf    = 1'b0;
      m_zero   = 1'b0;
    end else if (ph < 0) begin
      if (start) begin
        m_a = a;
        m_b = b;
        ph  = 0;
      end
    end else if (ph == W) begin
      ph = -1;
    end else begin
      ph++;
      if (ph == W) begin
        m_diff   = W'(int'(m_a) - int'(m_b));
        m_borrow = (m_a < m_b);
        sa       = to_signed(m_a);
        sb       = to_signed(m_b);
        sd       = sa - sb;
        m_ovf    = (sd > 2 ** (W - 1) - 1) || (sd < -(2 ** (W - 1)));
        m_zero   = (m_diff == '0);
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("busy",     busy,     (ph >= 0 && ph < W));
    check("done",     done,     (ph == W));
    check("diff",     diff,     m_diff);
    check("borrow",   borrow,   m_borrow);
    check("overflow", overflow, m_ovf);
    check("zero",     zero,     m_zero);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Raise start until the DUT reports busy (bounded), then drop it.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    #1;
    a     = x;
    b     = y;
    start = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (busy) break;
    end
    check("accept_timeout", busy, 1);
    start = 1'b0;
  endtask

  // Count edges until done; exp_lat is the number of edges still expected.
  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    check("done_latency", lat, exp_lat);
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] e_diff, input logic e_br,
                          input logic e_ov, input logic e_z);
    issue(x, y);
    wait_done(W);
    check("lit_diff",     diff,     e_diff);
    check("lit_borrow",   borrow,   e_br);
    check("lit_overflow", overflow, e_ov);
    check("lit_zero",     zero,     e_z);
  endtask

  initial begin
    #12 rst_n = 1'b1;

    // Directed cases with hand-computed results.
    directed(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0);
    directed(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0);
    directed(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    directed(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    directed(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1);
    directed(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);

    // start pulsed and operands changed mid-RUN must be ignored.
    issue(8'h35, 8'h12);
    @(posedge clk);
    @(negedge clk);
    #1;
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'hC3;
    b     = 8'h9E;
    wait_done(W - 2);
    check("midrun_diff", diff, 8'h23);
    repeat (4) begin
      @(negedge clk);
      check("no_second_op", busy, 0);
    end

    // Asynchronous reset in the middle of RUN clears outputs immediately.
    issue(8'h10, 8'h20);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    check("rst_diff",     diff,     0);
    check("rst_borrow",   borrow,   0);
    check("rst_overflow", overflow, 0);
    check("rst_zero",     zero,     0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    directed(8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);

    // Random operations, model-checked every cycle.
    repeat (40) begin
      issue(W'($urandom), W'($urandom));
      wait_done(W);
    end

    // start held high: re-accepted in the first IDLE cycle after each DONE.
    @(negedge clk);
    #1;
    start = 1'b1;
    repeat (40) begin
      @(negedge clk);
      #1;
      a = W'($urandom);
      b = W'($urandom);
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
